lsu_mem_stage: RTL

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

---
 rtl/lsu_mem_stage.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32 load/store MEM stage driving a req/gnt/rvalid data-memory port.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module lsu_mem_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    MEM_RD_mem_i,
  input  logic                    MEM_WR_mem_i,
  input  logic [3:0]              MEM_mem_op_i,
  input  logic [31:0]             MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0]   MEM_rs2_data_i,
  input  logic [4:0]              MEM_rd_add_i,
  input  logic                    MEM_regwrite_i,
  output logic                    dmem_req_o,
  output logic                    dmem_we_o,
  output logic [DATA_WIDTH/8-1:0] dmem_be_o,
  output logic [31:0]             dmem_addr_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  input  logic                    dmem_gnt_i,
  input  logic                    dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
  output logic                    MEM_stall_o,
  output logic [DATA_WIDTH-1:0]   MEM_wb_data_o,
  output logic [4:0]              MEM_rd_add_o,
  output logic                    MEM_regwrite_o,
  output logic                    MEM_misaligned_o
);
  localparam int unsigned AW  = 32;
  localparam int unsigned BEW = DATA_WIDTH / 8;
  localparam int unsigned RW  = 5;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t                r_state, w_state_nxt;
  logic [AW-1:0]         r_addr;
  logic                  r_we;
  logic [BEW-1:0]        r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [RW-1:0]         r_rd;
  logic [2:0]            r_op;
  logic                  r_regwrite;

  logic                  w_is_mem, w_is_store, w_access;
  logic [1:0]            w_size;
  logic [AW-1:0]         w_addr;
  logic [BEW-1:0]        w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_load;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_wb_data;
  logic [RW-1:0]         w_wb_rd;
  logic                  w_wb_we;
  logic                  w_unused;

  assign w_unused   = MEM_mem_op_i[3];
  assign w_is_mem   = MEM_RD_mem_i | MEM_WR_mem_i;
  assign w_is_store = MEM_WR_mem_i;
  assign w_size     = MEM_mem_op_i[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((w_size == 2'b01) && MEM_alu_result_i[0]) ||
                      (w_size[1] && (MEM_alu_result_i[1:0] != 2'b00));
  assign w_access   = w_is_mem & ~w_misalign;
  assign w_addr     = MEM_alu_result_i;
`else
  // Misaligned halves/words are silently pulled down to their natural alignment.
  assign w_access = w_is_mem;
  assign w_addr   = {MEM_alu_result_i[AW-1:2],
                     MEM_alu_result_i[1] & ~w_size[1],
                     MEM_alu_result_i[0] & (w_size == 2'b00)};
`endif

  // Store lane mask and lane-replicated write data
  always_comb begin
    w_be    = '1;
    w_wdata = MEM_rs2_data_i;
    case (w_size)
      2'b00: begin
        w_be    = BEW'(1) << w_addr[1:0];
        w_wdata = {4{MEM_rs2_data_i[7:0]}};
      end
      2'b01: begin
        w_be    = w_addr[1] ? BEW'(4'b1100) : BEW'(4'b0011);
        w_wdata = {2{MEM_rs2_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension, keyed on the latched address/op
  always_comb begin
    w_byte = dmem_rdata_i[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = dmem_rdata_i[15:8];
      2'd2:    w_byte = dmem_rdata_i[23:16];
      2'd3:    w_byte = dmem_rdata_i[31:24];
      default: ;
    endcase
    w_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (r_op)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_access) w_state_nxt = dmem_gnt_i ? S_WAIT : S_REQ;
      S_REQ:   if (dmem_gnt_i) w_state_nxt = S_WAIT;
      S_WAIT:  if (dmem_rvalid_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Memory channel, stall and next MEM/WB payload
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_be_o    = '0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    MEM_stall_o  = 1'b0;
    w_wb_data    = '0;
    w_wb_rd      = '0;
    w_wb_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = w_is_store;
          dmem_be_o    = w_be;
          dmem_addr_o  = {w_addr[AW-1:2], 2'b00};
          dmem_wdata_o = w_wdata;
          MEM_stall_o  = 1'b1;
        end else if (!w_is_mem) begin
          w_wb_data = MEM_alu_result_i;
          w_wb_rd   = MEM_rd_add_i;
          w_wb_we   = MEM_regwrite_i;
        end
      end
      S_REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = r_we;
        dmem_be_o    = r_be;
        dmem_addr_o  = {r_addr[AW-1:2], 2'b00};
        dmem_wdata_o = r_wdata;
        MEM_stall_o  = 1'b1;
      end
      S_WAIT: begin
        MEM_stall_o = ~dmem_rvalid_i;
        if (dmem_rvalid_i && !r_we) begin
          w_wb_data = w_load;
          w_wb_rd   = r_rd;
          w_wb_we   = r_regwrite;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      dmem_req_o  = 1'b0;
      MEM_stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_op       <= '0;
      r_regwrite <= 1'b0;
    end else if (r_state == S_IDLE && w_access) begin
      r_addr     <= w_addr;
      r_we       <= w_is_store;
      r_be       <= w_be;
      r_wdata    <= w_wdata;
      r_rd       <= MEM_rd_add_i;
      r_op       <= MEM_mem_op_i[2:0];
      r_regwrite <= MEM_regwrite_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_wb_data_o  <= '0;
      MEM_rd_add_o   <= '0;
      MEM_regwrite_o <= 1'b0;
    end else begin
      MEM_wb_data_o  <= w_wb_data;
      MEM_rd_add_o   <= w_wb_rd;
      MEM_regwrite_o <= w_wb_we;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) MEM_misaligned_o <= 1'b0;
    else        MEM_misaligned_o <= (r_state == S_IDLE) && w_is_mem && w_misalign;
  end
`else
  assign MEM_misaligned_o = 1'b0;
`endif

endmodule
